// File: rtl/axi4_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi4_lite_pkg
// Shared AXI4-Lite definitions used by the control master, the GPU control
// slave and other AXI-Lite register blocks.
//   resp_t          : xRESP encoding (OKAY, EXOKAY, SLVERR, DECERR)
//   master_state_t  : control-master FSM states
//   sat_inc8        : 8-bit saturating increment used for error counters
// -----------------------------------------------------------------------------
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } master_state_t;

  // Increment that sticks at 8'hFF instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    if (value == 8'hFF) begin
      return value;
    end else begin
      return value + 8'd1;
    end
  endfunction

endpackage

// File: rtl/axi4_lite_ctrl_master.sv
// -----------------------------------------------------------------------------
// axi4_lite_ctrl_master
// Single-outstanding AXI4-Lite initiator. Accepts one read/write command on a
// valid/ready command port, runs the AXI transaction, and returns read data and
// the response code on a valid/ready response port.
//
// Ports:
//   m_axi_ctrl_aclk / m_axi_ctrl_areset : clock, async active-high reset
//   cmd_valid/ready/write/addr/wdata    : command port
//   rsp_valid/ready/rdata/resp          : response port
//   err_count                           : saturating count of non-OKAY responses
//   m_axi_ctrl_*                        : AXI4-Lite master AW/W/B/AR/R channels
//
// Build option:
//   AXI_MASTER_WSTRB_EN : adds cmd_wstrb and m_axi_ctrl_wstrb. When undefined
//                         the slave sees all-ones strobe semantics.
//
// All outputs come straight from flops, so reset clears them immediately.
// -----------------------------------------------------------------------------
module axi4_lite_ctrl_master
  import axi4_lite_pkg::*;
#(
  parameter int AXI_ADDRESS_WIDTH = 32,
  parameter int AXI_DATA_WIDTH    = 32
) (
  input  logic                         m_axi_ctrl_aclk,
  input  logic                         m_axi_ctrl_areset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [AXI_ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]    cmd_wdata,
`ifdef AXI_MASTER_WSTRB_EN
  input  logic [AXI_DATA_WIDTH/8-1:0]  cmd_wstrb,
`endif
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0]    rsp_rdata,
  output logic [1:0]                   rsp_resp,
  output logic [7:0]                   err_count,
  output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_ctrl_awaddr,
  output logic                         m_axi_ctrl_awvalid,
  input  logic                         m_axi_ctrl_awready,
  output logic [AXI_DATA_WIDTH-1:0]    m_axi_ctrl_wdata,
`ifdef AXI_MASTER_WSTRB_EN
  output logic [AXI_DATA_WIDTH/8-1:0]  m_axi_ctrl_wstrb,
`endif
  output logic                         m_axi_ctrl_wvalid,
  input  logic                         m_axi_ctrl_wready,
  input  logic [1:0]                   m_axi_ctrl_bresp,
  input  logic                         m_axi_ctrl_bvalid,
  output logic                         m_axi_ctrl_bready,
  output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_ctrl_araddr,
  output logic                         m_axi_ctrl_arvalid,
  input  logic                         m_axi_ctrl_arready,
  input  logic [AXI_DATA_WIDTH-1:0]    m_axi_ctrl_rdata,
  input  logic [1:0]                   m_axi_ctrl_rresp,
  input  logic                         m_axi_ctrl_rvalid,
  output logic                         m_axi_ctrl_rready
);

  localparam int ADDR_LSB = $clog2(AXI_DATA_WIDTH / 8);
  // Clears the byte-offset bits so every access is bus-word aligned.
  localparam logic [AXI_ADDRESS_WIDTH-1:0] ADDR_MASK =
    {{(AXI_ADDRESS_WIDTH - ADDR_LSB){1'b1}}, {ADDR_LSB{1'b0}}};

  master_state_t               state, state_next;
  logic                        aw_done, aw_done_next;
  logic                        w_done, w_done_next;
  logic [AXI_ADDRESS_WIDTH-1:0] addr, addr_next;
  logic [AXI_DATA_WIDTH-1:0]   wdata_next;
  logic                        cmd_ready_next, rsp_valid_next;
  logic [AXI_DATA_WIDTH-1:0]   rsp_rdata_next;
  logic [1:0]                  rsp_resp_next;
  logic [7:0]                  err_count_next;
  logic                        awvalid_next, wvalid_next, bready_next;
  logic                        arvalid_next, rready_next;
`ifdef AXI_MASTER_WSTRB_EN
  logic [AXI_DATA_WIDTH/8-1:0] wstrb_next;
`endif

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs = m_axi_ctrl_awvalid && m_axi_ctrl_awready;
  assign w_hs  = m_axi_ctrl_wvalid  && m_axi_ctrl_wready;
  assign b_hs  = m_axi_ctrl_bvalid  && m_axi_ctrl_bready;
  assign ar_hs = m_axi_ctrl_arvalid && m_axi_ctrl_arready;
  assign r_hs  = m_axi_ctrl_rvalid  && m_axi_ctrl_rready;

  // One latched address serves both address channels; only one is ever valid.
  assign m_axi_ctrl_awaddr = addr;
  assign m_axi_ctrl_araddr = addr;

  // Next-state and next-output computation for the transaction FSM.
  always_comb begin
    state_next     = state;
    aw_done_next   = aw_done;
    w_done_next    = w_done;
    addr_next      = addr;
    wdata_next     = m_axi_ctrl_wdata;
    cmd_ready_next = 1'b0;
    rsp_valid_next = rsp_valid;
    rsp_rdata_next = rsp_rdata;
    rsp_resp_next  = rsp_resp;
    err_count_next = err_count;
    awvalid_next   = m_axi_ctrl_awvalid;
    wvalid_next    = m_axi_ctrl_wvalid;
    bready_next    = m_axi_ctrl_bready;
    arvalid_next   = m_axi_ctrl_arvalid;
    rready_next    = m_axi_ctrl_rready;
`ifdef AXI_MASTER_WSTRB_EN
    wstrb_next     = m_axi_ctrl_wstrb;
`endif

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_next  = cmd_addr & ADDR_MASK;
          wdata_next = cmd_wdata;
`ifdef AXI_MASTER_WSTRB_EN
          wstrb_next = cmd_wstrb;
`endif
          if (cmd_write) begin
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
            aw_done_next = 1'b0;
            w_done_next  = 1'b0;
            state_next   = WR_REQ;
          end else begin
            arvalid_next = 1'b1;
            state_next   = RD_REQ;
          end
        end else begin
          // Registered ready: first asserted one edge after entering IDLE.
          cmd_ready_next = 1'b1;
        end
      end

      WR_REQ: begin
        // AW and W retire independently; each VALID holds until its own handshake.
        awvalid_next = m_axi_ctrl_awvalid && !aw_hs;
        wvalid_next  = m_axi_ctrl_wvalid  && !w_hs;
        aw_done_next = aw_done || aw_hs;
        w_done_next  = w_done  || w_hs;
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          bready_next = 1'b1;
          state_next  = WR_RESP;
        end else begin
          state_next  = WR_REQ;
        end
      end

      WR_RESP: begin
        if (b_hs) begin
          bready_next    = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = '0;
          rsp_resp_next  = m_axi_ctrl_bresp;
          err_count_next = (m_axi_ctrl_bresp != OKAY) ? sat_inc8(err_count) : err_count;
          state_next     = RSP;
        end else begin
          state_next     = WR_RESP;
        end
      end

      RD_REQ: begin
        if (ar_hs) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          state_next   = RD_RESP;
        end else begin
          state_next   = RD_REQ;
        end
      end

      RD_RESP: begin
        if (r_hs) begin
          rready_next    = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = m_axi_ctrl_rdata;
          rsp_resp_next  = m_axi_ctrl_rresp;
          err_count_next = (m_axi_ctrl_rresp != OKAY) ? sat_inc8(err_count) : err_count;
          state_next     = RSP;
        end else begin
          state_next     = RD_RESP;
        end
      end

      RSP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end else begin
          state_next     = RSP;
        end
      end

      default: begin
        // Unreachable encoding: park safely with every handshake dropped.
        awvalid_next   = 1'b0;
        wvalid_next    = 1'b0;
        bready_next    = 1'b0;
        arvalid_next   = 1'b0;
        rready_next    = 1'b0;
        rsp_valid_next = 1'b0;
        state_next     = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge m_axi_ctrl_aclk or posedge m_axi_ctrl_areset) begin
    if (m_axi_ctrl_areset) begin
      state              <= IDLE;
      aw_done            <= 1'b0;
      w_done             <= 1'b0;
      addr               <= '0;
      m_axi_ctrl_wdata   <= '0;
      cmd_ready          <= 1'b0;
      rsp_valid          <= 1'b0;
      rsp_rdata          <= '0;
      rsp_resp           <= 2'b00;
      err_count          <= 8'h00;
      m_axi_ctrl_awvalid <= 1'b0;
      m_axi_ctrl_wvalid  <= 1'b0;
      m_axi_ctrl_bready  <= 1'b0;
      m_axi_ctrl_arvalid <= 1'b0;
      m_axi_ctrl_rready  <= 1'b0;
`ifdef AXI_MASTER_WSTRB_EN
      m_axi_ctrl_wstrb   <= '0;
`endif
    end else begin
      state              <= state_next;
      aw_done            <= aw_done_next;
      w_done             <= w_done_next;
      addr               <= addr_next;
      m_axi_ctrl_wdata   <= wdata_next;
      cmd_ready          <= cmd_ready_next;
      rsp_valid          <= rsp_valid_next;
      rsp_rdata          <= rsp_rdata_next;
      rsp_resp           <= rsp_resp_next;
      err_count          <= err_count_next;
      m_axi_ctrl_awvalid <= awvalid_next;
      m_axi_ctrl_wvalid  <= wvalid_next;
      m_axi_ctrl_bready  <= bready_next;
      m_axi_ctrl_arvalid <= arvalid_next;
      m_axi_ctrl_rready  <= rready_next;
`ifdef AXI_MASTER_WSTRB_EN
      m_axi_ctrl_wstrb   <= wstrb_next;
`endif
    end
  end

endmodule
